// File: rtl/chunked_adder_pkg.sv
// Shared types and elaboration helpers for the chunk-serial adder/subtractor.
package chunked_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk configuration still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunked_adder_if.sv
// Start/done request bus of the chunk-serial adder: operands in, result and status out.
interface chunked_adder_if #(parameter int WIDTH = 16);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;

  modport master (output start, sub, a, b, c_in,
                  input  busy, done, s, c_out, ovf);
  modport slave  (input  start, sub, a, b, c_in,
                  output busy, done, s, c_out, ovf);
endinterface

// File: rtl/chunked_adder_ripple.sv
// Combinational CHUNK-bit ripple-carry adder; also exposes the carry into its top bit.
module chunk_ripple #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_ci,
  output logic [CHUNK-1:0] o_s,
  output logic             o_co,
  output logic             o_c_msb_in
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = i_ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_co       = w_c[CHUNK];
  assign o_c_msb_in = w_c[CHUNK-1];

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per clock, carry held in r_cr.
// state | meaning
// IDLE  | waiting for start
// RUN   | adding slice r_k, busy high
// DONE  | one-cycle done pulse, result valid; start here is accepted
module chunked_adder
  import chunked_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic clk,
  input  logic reset,
  chunked_adder_if.slave bus
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CW     = cnt_width(NCHUNK);

  if (CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_chunk
    $error("chunked_adder: CHUNK must be in 1..WIDTH");
  end
  if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("chunked_adder: WIDTH must be a multiple of CHUNK");
  end

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_k;
  logic [WIDTH-1:0] r_a, r_b, r_s;
  logic             r_cr, r_cout, r_ovf;

  logic [CHUNK-1:0] w_sum;
  logic             w_co, w_c_msb;
  logic             w_accept, w_last;
  int unsigned      w_base;

  assign w_accept = bus.start && (r_state != RUN);
  assign w_last   = (r_k == CW'(NCHUNK - 1));
  assign w_base   = 32'(r_k) * 32'(CHUNK);

  chunk_ripple #(.CHUNK(CHUNK)) u_ripple (
    .i_a        (r_a[w_base +: CHUNK]),
    .i_b        (r_b[w_base +: CHUNK]),
    .i_ci       (r_cr),
    .o_s        (w_sum),
    .o_co       (w_co),
    .o_c_msb_in (w_c_msb)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = bus.start ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_cr    <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        // Subtract is a + ~b + 1; the result register is left alone until slices land.
        r_a  <= bus.a;
        r_b  <= bus.sub ? ~bus.b : bus.b;
        r_cr <= bus.sub ? 1'b1 : bus.c_in;
        r_k  <= '0;
      end else if (r_state == RUN) begin
        r_s[w_base +: CHUNK] <= w_sum;
        r_cr                 <= w_co;
        r_k                  <= r_k + CW'(1);
        if (w_last) begin
          r_cout <= w_co;
          r_ovf  <= w_c_msb ^ w_co;
        end
      end
    end
  end

  assign bus.busy  = (r_state == RUN);
  assign bus.done  = (r_state == DONE);
  assign bus.s     = r_s;
  assign bus.c_out = r_cout;
  assign bus.ovf   = r_ovf;

endmodule

// File: tb/tb_chunked_adder.sv
// Directed and randomised checks of chunked_adder in four (WIDTH, CHUNK) configurations.
module tb_chunked_adder;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  chunked_adder_if #(.WIDTH(16)) ifa ();
  chunked_adder_if #(.WIDTH(8))  ifb ();
  chunked_adder_if #(.WIDTH(16)) ifc ();
  chunked_adder_if #(.WIDTH(32)) ifd ();

  chunked_adder #(.WIDTH(16), .CHUNK(4))  u_a (.clk(clk), .reset(reset), .bus(ifa));
  chunked_adder #(.WIDTH(8),  .CHUNK(1))  u_b (.clk(clk), .reset(reset), .bus(ifb));
  chunked_adder #(.WIDTH(16), .CHUNK(16)) u_c (.clk(clk), .reset(reset), .bus(ifc));
  chunked_adder #(.WIDTH(32), .CHUNK(8))  u_d (.clk(clk), .reset(reset), .bus(ifd));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int id, input logic st, input logic sb,
                       input logic [63:0] a, input logic [63:0] b, input logic ci);
    case (id)
      0: begin ifa.start = st; ifa.sub = sb; ifa.a = a[15:0]; ifa.b = b[15:0]; ifa.c_in = ci; end
      1: begin ifb.start = st; ifb.sub = sb; ifb.a = a[7:0];  ifb.b = b[7:0];  ifb.c_in = ci; end
      2: begin ifc.start = st; ifc.sub = sb; ifc.a = a[15:0]; ifc.b = b[15:0]; ifc.c_in = ci; end
      default: begin ifd.start = st; ifd.sub = sb; ifd.a = a[31:0]; ifd.b = b[31:0]; ifd.c_in = ci; end
    endcase
  endtask

  task automatic sample(input int id, output logic bz, output logic dn,
                        output logic [63:0] s, output logic co, output logic ov);
    case (id)
      0: begin bz = ifa.busy; dn = ifa.done; s = 64'(ifa.s); co = ifa.c_out; ov = ifa.ovf; end
      1: begin bz = ifb.busy; dn = ifb.done; s = 64'(ifb.s); co = ifb.c_out; ov = ifb.ovf; end
      2: begin bz = ifc.busy; dn = ifc.done; s = 64'(ifc.s); co = ifc.c_out; ov = ifc.ovf; end
      default: begin bz = ifd.busy; dn = ifd.done; s = 64'(ifd.s); co = ifd.c_out; ov = ifd.ovf; end
    endcase
  endtask

  // Called at a falling edge; returns latency in cycles and whether done is still high a cycle later.
  task automatic run_op(input int id, input logic sb, input logic [63:0] a, input logic [63:0] b,
                        input logic ci, output int lat, output logic [63:0] s,
                        output logic co, output logic ov, output logic dn_after);
    logic bz, dn;
    logic [63:0] s2;
    logic co2, ov2;
    drive(id, 1'b1, sb, a, b, ci);
    @(negedge clk);
    drive(id, 1'b0, sb, a, b, ci);
    lat = 0;
    sample(id, bz, dn, s, co, ov);
    while (!dn && lat < 64) begin
      @(negedge clk);
      lat++;
      sample(id, bz, dn, s, co, ov);
    end
    @(negedge clk);
    sample(id, bz, dn_after, s2, co2, ov2);
  endtask

  task automatic ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                           input logic sb, input logic ci,
                           output logic [63:0] s, output logic co, output logic ov);
    logic [63:0] mask, beff;
    logic [64:0] t;
    mask = (64'd1 << w) - 64'd1;
    beff = (sb ? ~b : b) & mask;
    t    = {1'b0, a & mask} + {1'b0, beff} + 65'(sb ? 1'b1 : ci);
    s    = t[63:0] & mask;
    co   = t[w];
    ov   = (a[w-1] == beff[w-1]) && (s[w-1] != a[w-1]);
  endtask

  task automatic directed(input int id, input int nch, input string tag, input logic sb,
                          input logic [63:0] a, input logic [63:0] b, input logic ci,
                          input logic [63:0] es, input logic ec, input logic eo);
    int lat;
    logic [63:0] s;
    logic co, ov, dn_after;
    run_op(id, sb, a, b, ci, lat, s, co, ov, dn_after);
    check({tag, "_latency"}, 64'(lat), 64'(nch));
    check({tag, "_s"}, s, es);
    check({tag, "_c_out"}, 64'(co), 64'(ec));
    check({tag, "_ovf"}, 64'(ov), 64'(eo));
    check({tag, "_done_width"}, 64'(dn_after), 64'd0);
  endtask

  initial begin
    logic [9:0] acc;
    logic pb, stable;
    int seen, ndone;

    reset = 1'b1;
    for (int id = 0; id < 4; id++) drive(id, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(ifa.busy), 64'd0);
    check("rst_done", 64'(ifa.done), 64'd0);
    check("rst_s", 64'(ifa.s), 64'd0);
    check("rst_c_out", 64'(ifa.c_out), 64'd0);
    check("rst_ovf", 64'(ifa.ovf), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    directed(0, 4, "add_plain", 1'b0, 64'h1234, 64'h4321, 1'b0, 64'h5555, 1'b0, 1'b0);
    directed(0, 4, "add_wrap",  1'b0, 64'hFFFF, 64'h0001, 1'b0, 64'h0000, 1'b1, 1'b0);
    directed(0, 4, "add_ovf",   1'b0, 64'h7FFF, 64'h0001, 1'b0, 64'h8000, 1'b0, 1'b1);
    directed(0, 4, "add_cin",   1'b0, 64'h00FF, 64'h0F00, 1'b1, 64'h1000, 1'b0, 1'b0);
    directed(0, 4, "sub_borrow", 1'b1, 64'h0005, 64'h0007, 1'b1, 64'hFFFE, 1'b0, 1'b0);
    directed(0, 4, "sub_ovf",   1'b1, 64'h8000, 64'h0001, 1'b0, 64'h7FFF, 1'b1, 1'b1);

    // Start held high: accepted from IDLE and again from DONE, never during RUN.
    drive(0, 1'b1, 1'b0, 64'h0001, 64'h0001, 1'b0);
    pb = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      acc[i] = ifa.busy && !pb;
      pb = ifa.busy;
    end
    drive(0, 1'b0, 1'b0, 64'h0001, 64'h0001, 1'b0);
    check("hs_accept_cycles", 64'(acc), 64'b0000100001);
    @(negedge clk);
    check("hs_idle_after", 64'({ifa.busy, ifa.done}), 64'd0);
    check("hs_s", 64'(ifa.s), 64'h0002);

    directed(0, 4, "prep_5555", 1'b0, 64'h1234, 64'h4321, 1'b0, 64'h5555, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b0, 64'h1234, 64'h4321, 1'b0);
    stable = 1'b1;
    seen = -1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 1) drive(0, 1'b1, 1'b0, 64'hFFFF, 64'hFFFF, 1'b0);
      else        drive(0, 1'b0, 1'b0, 64'hFFFF, 64'hFFFF, 1'b0);
      if (ifa.s !== 16'h5555) stable = 1'b0;
      if (ifa.done) begin
        ndone++;
        if (seen < 0) seen = i;
      end
    end
    check("midrun_done_cycle", 64'(seen), 64'd4);
    check("midrun_done_count", 64'(ndone), 64'd1);
    check("midrun_s_stable", 64'(stable), 64'd1);
    check("midrun_idle", 64'(ifa.busy), 64'd0);

    directed(1, 8, "w8c1_add",   1'b0, 64'h80, 64'h80, 1'b0, 64'h00, 1'b1, 1'b1);
    directed(2, 1, "w16c16_cin", 1'b0, 64'hFFFF, 64'h0000, 1'b1, 64'h0000, 1'b1, 1'b0);
    directed(3, 4, "w32c8_sub",  1'b1, 64'h12345678, 64'h12345679, 1'b0, 64'hFFFFFFFF, 1'b0, 1'b0);

    for (int id = 1; id < 4; id++) begin
      int w, nch, lat;
      logic [63:0] mask, a, b, s, es;
      logic sb, ci, co, ov, dn_after, eco, eov;
      w   = (id == 1) ? 8 : (id == 2) ? 16 : 32;
      nch = (id == 1) ? 8 : (id == 2) ? 1 : 4;
      mask = (64'd1 << w) - 64'd1;
      for (int n = 0; n < 1000; n++) begin
        a  = {$urandom(), $urandom()} & mask;
        b  = {$urandom(), $urandom()} & mask;
        sb = 1'($urandom_range(0, 1));
        ci = 1'($urandom_range(0, 1));
        ref_model(w, a, b, sb, ci, es, eco, eov);
        run_op(id, sb, a, b, ci, lat, s, co, ov, dn_after);
        check($sformatf("sweep_w%0d_n%0d", w, n),
              {21'd0, dn_after, 8'(lat), co, ov, s[31:0]},
              {21'd0, 1'b0, 8'(nch), eco, eov, es[31:0]});
      end
    end

    drive(0, 1'b1, 1'b0, 64'hFFFF, 64'hFFFF, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 64'hFFFF, 64'hFFFF, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rstrun_busy", 64'(ifa.busy), 64'd0);
    check("rstrun_done", 64'(ifa.done), 64'd0);
    check("rstrun_s", 64'(ifa.s), 64'd0);
    check("rstrun_c_out", 64'(ifa.c_out), 64'd0);
    check("rstrun_ovf", 64'(ifa.ovf), 64'd0);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ifa.done || ifa.busy) ndone++;
    end
    check("rstrun_no_done", 64'(ndone), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chunked_adder.md
# chunked_adder

Parametrised multi-cycle adder/subtractor. It adds two WIDTH-bit operands CHUNK bits per clock, keeping the carry in a register between chunks, and reports the result through a start/done handshake. It is the area-scalable successor to the team's 4-bit ripple-carry adder. It sits wherever a wide add or subtract must fit a small combinational ripple path, for example datapath accumulators and address arithmetic.

## Interface
Parameters:
- WIDTH, 16: operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 4: bits added per cycle. Must be ≥1 and ≤WIDTH.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: request a new operation; sampled only when the block is ready.
- sub, input, 1: 0 computes a + b + c_in; 1 computes a − b (c_in ignored).
- a, input, WIDTH: operand A, captured on an accepted start.
- b, input, WIDTH: operand B, captured on an accepted start.
- c_in, input, 1: carry-in for add, captured on an accepted start.
- busy, output, 1: high while a computation is in progress.
- done, output, 1: one-cycle pulse when s, c_out and ovf become valid.
- s, output, WIDTH: result; holds until the next accepted start.
- c_out, output, 1: unsigned carry out. For subtract, 1 means no borrow (a ≥ b).
- ovf, output, 1: two's-complement overflow, equal to (carry into MSB) XOR (carry out of MSB).

## Operation
- NCHUNK = WIDTH/CHUNK.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1; a chunk counter k runs 0..NCHUNK−1.
  - DONE: done=1, busy=0; lasts exactly one cycle.
- Transitions:
  - IDLE→RUN on start.
  - RUN→DONE after the chunk with k=NCHUNK−1 is computed.
  - DONE→RUN on start, otherwise DONE→IDLE.
- Accepted start:
  - Latches a, b_eff (b_eff = b when sub=0, ~b when sub=1) and carry register cr (cr = c_in when sub=0, 1 when sub=1).
  - Clears k. s is not cleared.
- Each RUN cycle:
  - Bits [k·CHUNK +: CHUNK] of a, b_eff and cr feed the CHUNK-bit ripple adder.
  - The sum writes into the same bit slice of the result register; cr takes that chunk's carry out; k increments.
- On the final chunk:
  - c_out = final carry.
  - ovf = carry into MSB XOR final carry.
  - Both are registered on the same edge as the last sum slice.
- start is ignored in RUN, with no queueing. Operand inputs are don't-care except on the accepting edge.
- Reset at any time, including mid-RUN:
  - State goes to IDLE and k=0.
  - s=0, c_out=0, ovf=0, busy=0, done=0.
  - The operation in progress is discarded.
- Arithmetic is modulo 2^WIDTH. Results are bit-exact against a single-cycle WIDTH-bit add of a, b_eff and carry-in.

## Timing
- start is accepted at edge 0.
- busy is high from edge 0 through edge NCHUNK−1. done is high for the cycle after edge NCHUNK, so latency is NCHUNK cycles from start to done.
- s, c_out and ovf are valid in the done cycle and stay stable until the edge after the next accepted start.
- Back-to-back throughput: start asserted during done is accepted. One operation completes every NCHUNK+1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Degenerate case CHUNK=WIDTH: NCHUNK=1, with one RUN cycle and then DONE.

## Structure
- Shared package chunked_adder_pkg:
  - State enum (IDLE, RUN, DONE).
  - Helper for NCHUNK.
  - Counter-width constant $clog2(NCHUNK) with a minimum of 1.
- Sub-module chunk_ripple:
  - Combinational CHUNK-bit ripple-carry adder with inputs a, b, ci and outputs s, co, c_msb_in.
  - c_msb_in is the carry into the top bit, used for ovf.
  - Built from a generate loop of full-adder cells.
- Top level holds the FSM, chunk counter, operand/carry registers, the result register and the slice muxing.
- Elaboration-time check that WIDTH % CHUNK == 0.

## Test plan
Defaults WIDTH=16, CHUNK=4.
- Add, no carry: a=0x1234, b=0x4321, c_in=0 → done on the 4th cycle after start; s=0x5555, c_out=0, ovf=0.
- Wrap-around: a=0xFFFF, b=0x0001, c_in=0 → s=0x0000, c_out=1, ovf=0. Then a=0x7FFF, b=0x0001 → s=0x8000, c_out=0, ovf=1.
- Subtract: sub=1, a=0x0005, b=0x0007 → s=0xFFFE, c_out=0, ovf=0. Then a=0x8000, b=0x0001 → s=0x7FFF, c_out=1, ovf=1.
- Handshake: start held high for 10 cycles → operations start at cycles 0 and 5 only. A start pulse mid-RUN is ignored, and s is unchanged until the next done.
- Reset mid-RUN: start a=0xFFFF, b=0xFFFF, assert reset after 2 cycles → next cycle busy=0, done=0, s=0, c_out=0, ovf=0. No done pulse follows.
- Parameter sweep: (WIDTH, CHUNK) = (8,1), (16,16), (32,8) with 1000 random a, b, c_in, sub → results match the reference model; latency equals NCHUNK.
